// File: rtl/mu_pkg.sv
// Shared definitions for the measure-unit sequencer: register offsets of the
// target measure unit and the sequencer state encoding.
package mu_pkg;

  // Byte offsets of the measure-unit registers, relative to its base address.
  localparam logic [31:0] OFF_DELTA      = 32'h0000_0000;
  localparam logic [31:0] OFF_STB_CTL    = 32'h0000_0004;
  localparam logic [31:0] OFF_STB_PERIOD = 32'h0000_000C;
  localparam logic [31:0] OFF_MU_CTL     = 32'h0000_0010;
  localparam logic [31:0] OFF_CH1_VAL    = 32'h0000_0014;

  // Sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_DELTA,
    ST_W_STB,
    ST_P_RDY,
    ST_W_RUN,
    ST_P_PT,
    ST_PUSH,
    ST_W_STOP,
    ST_FIN
  } seq_state_e;

endpackage

// File: rtl/wb_single_access.sv
// One-access Wishbone classic initiator. A request is accepted whenever no
// cycle is in flight; cyc/stb then stay high until the first ack. The request
// is ignored during the ack cycle itself, so the bus always sees at least one
// idle cycle between two accesses. done_o and rdata_o are valid in the ack
// cycle only.
module wb_single_access (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  logic        act_q, act_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;

  // Launch a new access when idle, retire it on ack.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (otherwise synthesis infers a latch).
    act_d = act_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (act_q) begin
      if (wb_ack_i) act_d = 1'b0;
    end else if (req_i) begin
      act_d = 1'b1;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = dat_i;
    end
  end

  // Access registers; reset abandons any cycle in flight.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      act_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      act_q <= act_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  assign done_o   = act_q & wb_ack_i;
  assign rdata_o  = wb_dat_i;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = 4'hF;
  assign wb_cyc_o = act_q;
  assign wb_stb_o = act_q;

endmodule

// File: rtl/mu_seq_master.sv
// Measure-unit sequencer: programs delta and strobe control, waits for the
// strobe to be ready, runs the unit, streams n_points channel-1 samples out
// through a valid/ready port, then stops the unit and pulses done_o.
// Optional feature: define MU_SEQ_TIMEOUT_EN to bound each polling state to
// POLL_LIMIT consecutive not-ready reads (sets the sticky err_o and stops).
module mu_seq_master
  import mu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [15:0] POLL_LIMIT = 16'd1000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [25:0] delta_i,
  input  logic [15:0] n_points_i,
  input  logic        clk_sel_i,
  input  logic        mux_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] point_o,
  output logic        point_valid_o,
  input  logic        point_ready_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  seq_state_e  state_q, state_d;
  logic [25:0] delta_q, delta_d;
  logic [15:0] n_points_q, n_points_d;
  logic        clk_sel_q, clk_sel_d;
  logic        mux_q, mux_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] point_q, point_d;

  logic        acc_req, acc_we, acc_done;
  logic [31:0] acc_adr, acc_dat, acc_rdata;
  logic        poll_miss;

`ifdef MU_SEQ_TIMEOUT_EN
  logic [15:0] poll_q, poll_d;
  logic        err_q, err_d;
`endif

  // Next-state, bus request and datapath updates.
  always_comb begin
    state_d    = state_q;
    delta_d    = delta_q;
    n_points_d = n_points_q;
    clk_sel_d  = clk_sel_q;
    mux_d      = mux_q;
    cnt_d      = cnt_q;
    point_d    = point_q;
    acc_req    = 1'b0;
    acc_we     = 1'b0;
    acc_adr    = BASE_ADDR;
    acc_dat    = '0;
    poll_miss  = 1'b0;
`ifdef MU_SEQ_TIMEOUT_EN
    poll_d     = poll_q;
    err_d      = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          delta_d    = delta_i;
          n_points_d = n_points_i;
          clk_sel_d  = clk_sel_i;
          mux_d      = mux_i;
          cnt_d      = '0;
`ifdef MU_SEQ_TIMEOUT_EN
          err_d      = 1'b0;
`endif
          state_d    = ST_W_DELTA;
        end
      end
      ST_W_DELTA: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = BASE_ADDR + OFF_DELTA;
        acc_dat = {6'b0, delta_q};
        if (acc_done) state_d = ST_W_STB;
      end
      ST_W_STB: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = BASE_ADDR + OFF_STB_CTL;
        acc_dat = {29'b0, clk_sel_q, mux_q, 1'b1};
        if (acc_done) state_d = ST_P_RDY;
      end
      ST_P_RDY: begin
        acc_req = 1'b1;
        acc_adr = BASE_ADDR + OFF_STB_CTL;
        if (acc_done) begin
          if (acc_rdata[0]) state_d = ST_W_RUN;
          else              poll_miss = 1'b1;
        end
      end
      ST_W_RUN: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = BASE_ADDR + OFF_MU_CTL;
        acc_dat = 32'h1;
        if (acc_done) state_d = (n_points_q == 16'd0) ? ST_W_STOP : ST_P_PT;
      end
      ST_P_PT: begin
        acc_req = 1'b1;
        acc_adr = BASE_ADDR + OFF_CH1_VAL;
        if (acc_done) begin
          if (acc_rdata[0]) begin
            point_d = acc_rdata[16:1];
            state_d = ST_PUSH;
          end else begin
            poll_miss = 1'b1;
          end
        end
      end
      ST_PUSH: begin
        if (point_ready_i) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = (cnt_q + 16'd1 == n_points_q) ? ST_W_STOP : ST_P_PT;
        end
      end
      ST_W_STOP: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = BASE_ADDR + OFF_MU_CTL;
        acc_dat = 32'h0;
        if (acc_done) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef MU_SEQ_TIMEOUT_EN
    // Count consecutive not-ready reads; the count restarts in every state.
    if (poll_miss) begin
      if (poll_q == POLL_LIMIT - 16'd1) begin
        err_d   = 1'b1;
        state_d = ST_W_STOP;
      end else begin
        poll_d  = poll_q + 16'd1;
      end
    end
    if (state_d != state_q) poll_d = '0;
`endif
  end

  // Sequencer registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      delta_q    <= '0;
      n_points_q <= '0;
      clk_sel_q  <= 1'b0;
      mux_q      <= 1'b0;
      cnt_q      <= '0;
      point_q    <= '0;
    end else begin
      state_q    <= state_d;
      delta_q    <= delta_d;
      n_points_q <= n_points_d;
      clk_sel_q  <= clk_sel_d;
      mux_q      <= mux_d;
      cnt_q      <= cnt_d;
      point_q    <= point_d;
    end
  end

`ifdef MU_SEQ_TIMEOUT_EN
  // Poll-timeout counter and sticky error flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      poll_q <= '0;
      err_q  <= 1'b0;
    end else begin
      poll_q <= poll_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  // Polling is unbounded; the error flag can never be raised.
  logic unused_poll;
  assign unused_poll = poll_miss ^ (^POLL_LIMIT);
  assign err_o       = 1'b0;
`endif

  wb_single_access u_acc (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .req_i    (acc_req),
    .we_i     (acc_we),
    .adr_i    (acc_adr),
    .dat_i    (acc_dat),
    .done_o   (acc_done),
    .rdata_o  (acc_rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_we_o  (wb_we_o),
    .wb_sel_o (wb_sel_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i)
  );

  // Only the ready flag and the 16-bit sample field of read data matter.
  logic unused_rdata;
  assign unused_rdata = ^acc_rdata[31:17];

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_FIN);
  assign point_valid_o = (state_q == ST_PUSH);
  assign point_o       = point_q;

endmodule

// File: tb/tb_mu_seq_master.sv
// Directed bench for mu_seq_master with a Wishbone responder model.
// Honours MU_SEQ_TIMEOUT_EN for the poll-timeout scenario.
module tb_mu_seq_master;

  localparam logic [31:0] BASE = 32'h4000_0100;

  logic        wb_clk_i, wb_rst_i;
  logic        start_i;
  logic [25:0] delta_i;
  logic [15:0] n_points_i;
  logic        clk_sel_i, mux_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] point_o;
  logic        point_valid_o, point_ready_i;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
  logic [3:0]  wb_sel_o;

  mu_seq_master #(.BASE_ADDR(BASE), .POLL_LIMIT(16'd4)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .start_i       (start_i),
    .delta_i       (delta_i),
    .n_points_i    (n_points_i),
    .clk_sel_i     (clk_sel_i),
    .mux_i         (mux_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .point_o       (point_o),
    .point_valid_o (point_valid_o),
    .point_ready_i (point_ready_i),
    .wb_adr_o      (wb_adr_o),
    .wb_dat_o      (wb_dat_o),
    .wb_dat_i      (wb_dat_i),
    .wb_we_o       (wb_we_o),
    .wb_sel_o      (wb_sel_o),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_ack_i      (wb_ack_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Responder model state and logs.
  int          ack_delay = 1;
  int          wcnt      = 0;
  int          rdy_at    = 1;
  int          stb_polls = 0;
  bit          ch1_slow  = 0;
  bit          ch1_tog   = 0;
  logic [15:0] pts[$];
  logic [31:0] wr_adr[$];
  logic [31:0] wr_dat[$];
  int          n_rd_stb, n_rd_ch1, gap_viol, sel_viol, done_cnt;
  int          run_len, run_min, run_max, n_runs;
  logic [15:0] stream[$];

  task automatic clear_logs();
    wr_adr.delete(); wr_dat.delete(); stream.delete(); pts.delete();
    n_rd_stb = 0; n_rd_ch1 = 0; gap_viol = 0; sel_viol = 0; done_cnt = 0;
    run_min = 1000; run_max = 0; n_runs = 0; stb_polls = 0; ch1_tog = 0;
  endtask

  // Slave side: acknowledge after ack_delay cycles of stb, log the access.
  task automatic serve();
    logic [31:0] off;
    off = wb_adr_o - BASE;
    if (wb_sel_o != 4'hF) sel_viol++;
    if (wb_we_o) begin
      wr_adr.push_back(off);
      wr_dat.push_back(wb_dat_o);
      wb_dat_i = 32'hDEAD_BEEF;
    end else if (off == 32'h04) begin
      stb_polls++;
      n_rd_stb++;
      wb_dat_i = (rdy_at != 0 && stb_polls >= rdy_at) ? 32'h0000_0003 : 32'hFFFF_FFFE;
    end else if (off == 32'h14) begin
      n_rd_ch1++;
      if (ch1_slow && !ch1_tog) begin
        ch1_tog  = 1;
        wb_dat_i = 32'hFFFF_FFFE;
      end else if (pts.size() > 0) begin
        ch1_tog  = 0;
        wb_dat_i = {15'h2A5A, pts.pop_front(), 1'b1};
      end else begin
        wb_dat_i = 32'h0;
      end
    end else begin
      wb_dat_i = 32'h0;
    end
  endtask

  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_ack_i) begin
        wb_ack_i = 1'b0;
        wcnt     = 0;
        if (wb_cyc_o) gap_viol++;
      end else if (wb_cyc_o && wb_stb_o && !wb_rst_i) begin
        wcnt++;
        if (wcnt >= ack_delay) begin
          wb_ack_i = 1'b1;
          serve();
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Output monitor: stb run lengths, done pulses, stream transfers.
  initial begin
    run_len = 0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_stb_o) run_len++;
      else if (run_len > 0) begin
        n_runs++;
        if (run_len < run_min) run_min = run_len;
        if (run_len > run_max) run_max = run_len;
        run_len = 0;
      end
      if (done_o) done_cnt++;
      if (point_valid_o && point_ready_i) stream.push_back(point_o);
    end
  end

  task automatic start_seq(input logic [25:0] d, input logic [15:0] n, input logic cs, input logic mx);
    @(posedge wb_clk_i); #1;
    delta_i = d; n_points_i = n; clk_sel_i = cs; mux_i = mx; start_i = 1'b1;
    @(posedge wb_clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge wb_clk_i);
      if (done_o) begin ok = 1; break; end
    end
    check({tag, "_done_seen"}, ok, 1);
    @(negedge wb_clk_i);
    check({tag, "_idle_after"}, busy_o, 1'b0);
  endtask

  task automatic check_wr(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_wr_adr"}, (i < wr_adr.size()) ? wr_adr[i] : 32'hFFFF_FFFF, a);
    check({tag, "_wr_dat"}, (i < wr_dat.size()) ? wr_dat[i] : 32'hFFFF_FFFF, d);
  endtask

  function automatic logic [15:0] stream_at(input int i);
    return (i < stream.size()) ? stream[i] : 16'hFFFF;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok, bad, ch1_snap;
    wb_rst_i = 1'b1; start_i = 1'b0; delta_i = '0; n_points_i = '0;
    clk_sel_i = 1'b0; mux_i = 1'b0; point_ready_i = 1'b1;
    clear_logs();
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    // Reset state.
    check("rst_busy", busy_o, 0);
    check("rst_cyc_stb", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_flags", {done_o, err_o, point_valid_o}, 0);
    check("rst_point", point_o, 0);
    @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;

    // Basic sequence: ready on 2nd poll, three points, a start while busy.
    clear_logs();
    rdy_at = 2; pts = '{16'h0AAA, 16'h0BBB, 16'h0CCC};
    start_seq(26'h0010_0001, 16'd3, 1'b0, 1'b0);
    check("t1_busy", busy_o, 1);
    repeat (2) @(posedge wb_clk_i);
    start_seq(26'h3FF_FFFF, 16'd7, 1'b1, 1'b1);
    wait_done("t1");
    check("t1_wr_cnt", wr_adr.size(), 4);
    check_wr("t1_delta", 0, 32'h00, 32'h0010_0001);
    check_wr("t1_stbctl", 1, 32'h04, 32'h1);
    check_wr("t1_run", 2, 32'h10, 32'h1);
    check_wr("t1_stop", 3, 32'h10, 32'h0);
    check("t1_stb_reads", n_rd_stb, 2);
    check("t1_ch1_reads", n_rd_ch1, 3);
    check("t1_stream_cnt", stream.size(), 3);
    check("t1_pt0", stream_at(0), 16'h0AAA);
    check("t1_pt1", stream_at(1), 16'h0BBB);
    check("t1_pt2", stream_at(2), 16'h0CCC);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_err", err_o, 0);
    check("t1_gap", gap_viol, 0);
    check("t1_sel", sel_viol, 0);
    check("t1_runs", n_runs, 9);

    // Back-pressure: ready low 10 cycles during PUSH; slow CH1 data.
    clear_logs();
    rdy_at = 1; ch1_slow = 1; pts = '{16'h1234, 16'h0F0F};
    point_ready_i = 1'b0;
    start_seq(26'h2AA_5555, 16'd2, 1'b1, 1'b0);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge wb_clk_i);
      if (point_valid_o) begin ok = 1; break; end
    end
    check("t2_valid_seen", ok, 1);
    ch1_snap = n_rd_ch1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk_i);
      if (!point_valid_o || point_o !== 16'h1234) bad++;
    end
    check("t2_stall_hold", bad, 0);
    check("t2_no_ch1_read", n_rd_ch1, ch1_snap);
    check("t2_no_cyc", wb_cyc_o, 0);
    @(posedge wb_clk_i); #1 point_ready_i = 1'b1;
    wait_done("t2");
    ch1_slow = 0;
    check_wr("t2_delta", 0, 32'h00, 32'h02AA_5555);
    check_wr("t2_stbctl", 1, 32'h04, 32'h5);
    check("t2_ch1_reads", n_rd_ch1, 4);
    check("t2_stream_cnt", stream.size(), 2);
    check("t2_pt0", stream_at(0), 16'h1234);
    check("t2_pt1", stream_at(1), 16'h0F0F);

    // Zero points: no CH1_VAL reads, run then stop.
    clear_logs();
    rdy_at = 1;
    start_seq(26'h000_0001, 16'd0, 1'b0, 1'b1);
    wait_done("t3");
    check("t3_ch1_reads", n_rd_ch1, 0);
    check("t3_wr_cnt", wr_adr.size(), 4);
    check_wr("t3_stbctl", 1, 32'h04, 32'h3);
    check_wr("t3_run", 2, 32'h10, 32'h1);
    check_wr("t3_stop", 3, 32'h10, 32'h0);
    check("t3_stream_cnt", stream.size(), 0);
    check("t3_done_cnt", done_cnt, 1);

    // Slow slave: ack after 5 cycles of stb.
    clear_logs();
    ack_delay = 5; rdy_at = 1; pts = '{16'h7FFF};
    start_seq(26'h001_0002, 16'd1, 1'b0, 1'b0);
    wait_done("t4");
    ack_delay = 1;
    check("t4_run_min", run_min, 5);
    check("t4_run_max", run_max, 5);
    check("t4_runs", n_runs, 6);
    check("t4_gap", gap_viol, 0);
    check("t4_pt0", stream_at(0), 16'h7FFF);

    // Reset while a cycle awaits ack, then a clean full sequence.
    clear_logs();
    ack_delay = 50; rdy_at = 1;
    start_seq(26'h000_00FF, 16'd1, 1'b0, 1'b0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      if (wb_stb_o) begin ok = 1; break; end
    end
    check("t5_stb_seen", ok, 1);
    @(posedge wb_clk_i); #1 wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("t5_cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
    check("t5_busy", busy_o, 0);
    check("t5_adr", wb_adr_o, 0);
    wb_rst_i = 1'b0; ack_delay = 1;
    @(posedge wb_clk_i);
    clear_logs();
    pts = '{16'h0123};
    start_seq(26'h0AB_CDEF, 16'd1, 1'b0, 1'b0);
    wait_done("t5");
    check("t5_wr_cnt", wr_adr.size(), 4);
    check_wr("t5_delta", 0, 32'h00, 32'h00AB_CDEF);
    check("t5_pt0", stream_at(0), 16'h0123);

`ifdef MU_SEQ_TIMEOUT_EN
    // Strobe never ready: four polls, error, stop write, done.
    clear_logs();
    rdy_at = 0;
    start_seq(26'h000_0010, 16'd1, 1'b0, 1'b0);
    wait_done("t6");
    check("t6_stb_reads", n_rd_stb, 4);
    check("t6_err", err_o, 1);
    check("t6_wr_cnt", wr_adr.size(), 3);
    check_wr("t6_stop", 2, 32'h10, 32'h0);
    check("t6_ch1_reads", n_rd_ch1, 0);
    check("t6_done_cnt", done_cnt, 1);
    clear_logs();
    rdy_at = 1; pts = '{16'h0042};
    start_seq(26'h000_0010, 16'd1, 1'b0, 1'b0);
    check("t6_err_clear", err_o, 0);
    wait_done("t6b");
    check("t6_pt0", stream_at(0), 16'h0042);
`else
    // Unbounded polling: ready on the 5th read, no error.
    clear_logs();
    rdy_at = 5; pts = '{16'h0042};
    start_seq(26'h000_0010, 16'd1, 1'b0, 1'b0);
    wait_done("t6");
    check("t6_stb_reads", n_rd_stb, 5);
    check("t6_err", err_o, 0);
    check("t6_wr_cnt", wr_adr.size(), 4);
    check("t6_pt0", stream_at(0), 16'h0042);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
